// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared widths, constants and FSM encoding for the IF fetch unit
package if_fetch_unit_pkg;

  localparam int InstAddrBus = 32;
  localparam int MemDataBus  = 8;
  localparam int CntW        = 3;

  localparam logic [InstAddrBus-1:0] ZeroWord     = '0;
  localparam logic [CntW-1:0]        BytesPerInst = 3'd4;
  localparam logic [CntW-1:0]        LastByte     = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - byte-serial instruction fetch over a shared 8-bit memory port
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   flush_i,
  input  logic                   mem_busy_i,
  input  logic [MemDataBus-1:0]  mem_din_i,
  input  logic                   inst_ack_i,
  output logic                   if_mem_req_o,
  output logic [InstAddrBus-1:0] if_mem_addr_o,
  output logic [InstAddrBus-1:0] inst_o,
  output logic                   inst_valid_o,
  output logic                   fetch_busy_o
);

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [CntW-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]        recv_cnt_q, recv_cnt_d;
  logic                   pend_q, pend_d;
  logic [InstAddrBus-1:0] inst_q, inst_d;
  logic                   valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= ZeroWord;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= 1'b0;
      inst_q      <= ZeroWord;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pend_q      <= pend_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (fetch_en_i) state_d = ST_FETCH;
        ST_FETCH: if (pend_q && recv_cnt_q == LastByte) state_d = ST_DONE;
        ST_DONE:  if (inst_ack_i) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // A refused request (mem_busy_i) drops pending; the byte in flight from the previous edge still lands.
  always_comb begin
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pend_d      = pend_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    if (flush_i) begin
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
      pend_d      = 1'b0;
      valid_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_en_i) begin
            pc_d        = pc_i;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            pend_d      = 1'b0;
          end
        end
        ST_FETCH: begin
          if (if_mem_req_o && !mem_busy_i) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
            pend_d      = 1'b1;
          end else begin
            pend_d = 1'b0;
          end
          if (pend_q) begin
            inst_d[{recv_cnt_q[1:0], 3'b000} +: MemDataBus] = mem_din_i;
            recv_cnt_d = recv_cnt_q + 3'd1;
            if (recv_cnt_q == LastByte) valid_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (inst_ack_i) valid_d = 1'b0;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if_mem_req_o  = 1'b0;
    if_mem_addr_o = ZeroWord;
    if (state_q == ST_FETCH && issue_cnt_q < BytesPerInst) begin
      if_mem_req_o  = 1'b1;
      if_mem_addr_o = pc_q + {{(InstAddrBus-CntW){1'b0}}, issue_cnt_q};
    end
    fetch_busy_o = (state_q != ST_IDLE);
    inst_o       = inst_q;
    inst_valid_o = valid_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with a transaction-level model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic        inst_ack_i;
  logic        if_mem_req_o;
  logic [31:0] if_mem_addr_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        fetch_busy_o;

  int errors = 0;
  int checks = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en_i   (fetch_en_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .mem_busy_i   (mem_busy_i),
    .mem_din_i    (mem_din_i),
    .inst_ack_i   (inst_ack_i),
    .if_mem_req_o (if_mem_req_o),
    .if_mem_addr_o(if_mem_addr_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .fetch_busy_o (fetch_busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] lo;
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      default: begin
        lo = a[7:0] * 8'd7;
        return lo ^ a[15:8] ^ 8'hA5;
      end
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 fetching, 2 holding a finished word.
  int          m_phase = 0;
  bit          m_live = 0;
  logic [31:0] m_pc;
  int          m_served, m_edges, m_stalls;
  logic [31:0] m_inst;
  bit          m_inst_known = 0;
  bit          served_now = 0;
  logic [31:0] served_addr;
  logic [31:0] addr_log[$];

  always @(negedge clk) begin
    logic exp_req;
    if (m_live) begin
      exp_req = (m_phase == 1) && (m_served < 4);
      chk("mem_req", {31'b0, if_mem_req_o}, {31'b0, exp_req});
      chk("mem_addr", if_mem_addr_o, exp_req ? m_pc + 32'(m_served) : 32'h0);
      chk("fetch_busy", {31'b0, fetch_busy_o}, {31'b0, m_phase != 0});
      chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_phase == 2});
      if (m_inst_known) chk("inst", inst_o, m_inst);
    end
    served_now  = if_mem_req_o && !mem_busy_i;
    served_addr = if_mem_addr_o;
    if (if_mem_req_o === 1'b1 && !rst) addr_log.push_back(if_mem_addr_o);

    if (rst) begin
      m_live = 1; m_phase = 0; m_inst = 32'h0; m_inst_known = 1;
    end else if (m_live) begin
      if (flush_i) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (fetch_en_i) begin
          m_phase = 1; m_pc = pc_i; m_served = 0; m_edges = 0; m_stalls = 0;
          m_inst_known = 0;
        end
      end else if (m_phase == 1) begin
        m_edges++;
        if (m_served < 4) begin
          if (mem_busy_i) m_stalls++;
          else m_served++;
        end
        if (m_edges == 5 + m_stalls) begin
          m_phase = 2; m_inst = word_at(m_pc); m_inst_known = 1;
        end
      end else if (inst_ack_i) begin
        m_phase = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mem_din_i = served_now ? mem_byte(served_addr) : 8'hEE;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] pc, input logic [15:0] busy_mask,
                           input logic [15:0] ack_mask, output int lat);
    fetch_en_i = 1'b1;
    pc_i       = pc;
    tick();
    fetch_en_i = 1'b0;
    pc_i       = 32'hDEAD_BEEF;
    lat        = 0;
    mem_busy_i = busy_mask[0];
    inst_ack_i = ack_mask[0];
    while (!inst_valid_o && lat < 30) begin
      tick();
      lat++;
      mem_busy_i = (lat < 16) ? busy_mask[lat] : 1'b0;
      inst_ack_i = (lat < 16) ? ack_mask[lat] : 1'b0;
    end
    mem_busy_i = 1'b0;
    inst_ack_i = 1'b0;
    if (lat >= 30) chk("fetch_timeout", 32'(lat), 32'd0);
  endtask

  task automatic ack_inst();
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
  endtask

  initial begin
    int lat;
    int n1001;
    logic [31:0] w;
    rst = 1'b1; fetch_en_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    mem_busy_i = 1'b0; mem_din_i = 8'hEE; inst_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_req", {31'b0, if_mem_req_o}, 32'd0);
    chk("reset_inst", inst_o, 32'd0);
    chk("reset_busy", {31'b0, fetch_busy_o}, 32'd0);

    // plain fetch
    addr_log.delete();
    run_fetch(32'h0000_1000, 16'h0000, 16'h0000, lat);
    chk("plain_latency", 32'(lat), 32'd5);
    chk("plain_inst", inst_o, 32'h0010_0513);
    chk("plain_naddr", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < addr_log.size() && i < 4; i++)
      chk("plain_addr", addr_log[i], 32'h0000_1000 + 32'(i));

    // hold in DONE with fetch_en_i held high
    fetch_en_i = 1'b1;
    pc_i = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_inst", inst_o, 32'h0010_0513);
      chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
    end
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    fetch_en_i = 1'b0;
    chk("ack_idle_busy", {31'b0, fetch_busy_o}, 32'd0);
    chk("ack_idle_valid", {31'b0, inst_valid_o}, 32'd0);

    // contention on byte 1, plus a stray ack while fetching
    addr_log.delete();
    run_fetch(32'h0000_1000, 16'h0006, 16'h0018, lat);
    chk("busy_latency", 32'(lat), 32'd7);
    chk("busy_inst", inst_o, 32'h0010_0513);
    n1001 = 0;
    foreach (addr_log[i]) if (addr_log[i] == 32'h0000_1001) n1001++;
    chk("busy_hold_1001", 32'(n1001), 32'd3);
    chk("busy_naddr", 32'(addr_log.size()), 32'd6);
    ack_inst();

    // flush after two bytes, then flush beating fetch_en_i
    fetch_en_i = 1'b1; pc_i = 32'h0000_3000;
    tick();
    fetch_en_i = 1'b0;
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_req", {31'b0, if_mem_req_o}, 32'd0);
    chk("flush_busy", {31'b0, fetch_busy_o}, 32'd0);
    flush_i = 1'b1; fetch_en_i = 1'b1; pc_i = 32'h0000_4000;
    tick();
    flush_i = 1'b0; fetch_en_i = 1'b0;
    chk("flush_prio_busy", {31'b0, fetch_busy_o}, 32'd0);
    addr_log.delete();
    run_fetch(32'h0000_2000, 16'h0000, 16'h0000, lat);
    chk("refetch_latency", 32'(lat), 32'd5);
    chk("refetch_inst", inst_o, 32'h908B_8285);
    foreach (addr_log[i]) chk("refetch_addr", addr_log[i] & 32'hFFFF_FFFC, 32'h0000_2000);
    ack_inst();

    // address wrap
    addr_log.delete();
    run_fetch(32'hFFFF_FFFE, 16'h0000, 16'h0000, lat);
    chk("wrap_naddr", 32'(addr_log.size()), 32'd4);
    w = 32'hFFFF_FFFE;
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      chk("wrap_addr", addr_log[i], w);
      w = w + 32'd1;
    end
    chk("wrap_inst", inst_o, 32'hA2A5_A3A8);
    ack_inst();

    // reset mid-fetch
    fetch_en_i = 1'b1; pc_i = 32'h0000_1000;
    tick();
    fetch_en_i = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_req", {31'b0, if_mem_req_o}, 32'd0);
    chk("rst_addr", if_mem_addr_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy_o}, 32'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
